keypad_sync: RTL and testbench

Front-end keypad stage of the elevator simulator controller. Synchronizes 16 raw, bouncing key lines into the clock domain, debounces them, and priority-encodes them. Each accepted press is emitted as a single-cycle `pressed` strobe with a 4-bit key code on `buttonBus`. Its outputs drive the central FSM's `buttonBus`/`pressed` inputs directly, so the central FSM sees exactly one button event per physical press.

---
 rtl/keypad_sync.sv | 180 ++++++++++++++++++
 tb/tb_keypad_sync.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_sync.sv
// keypad_sync: front-end keypad stage for the elevator controller.
// Synchronizes 16 raw key lines, debounces press and release, priority-encodes
// the highest active key and emits a one-cycle `pressed` strobe with the key
// code on `buttonBus` once per accepted press.
//
// Optional build macro: KEYPAD_REPEAT_EN
//   defined   - UP (4'hC) / DOWN (4'hD) auto-repeat every REPEAT_CYCLES while held
//   undefined - exactly one strobe per press
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | no key down, waiting for any active line
// S_DEBOUNCE| candidate code captured, counting stable cycles
// S_HELD    | press accepted, waiting for release (repeat timer if enabled)
// S_RELEASE | all lines low, counting stable release cycles
module keypad_sync #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_CYCLES   = 200
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic [15:0] keys,
  output logic [3:0]  buttonBus,
  output logic        pressed
);

  // Counter is sized for the longer of the two periods so the repeat build
  // and the default build share one register layout.
  localparam int CNT_MAX = (DEBOUNCE_CYCLES > REPEAT_CYCLES) ? DEBOUNCE_CYCLES
                                                             : REPEAT_CYCLES;
  localparam int CW = $clog2(CNT_MAX);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
`ifdef KEYPAD_REPEAT_EN
  localparam logic [CW-1:0] RP_LAST = CW'(REPEAT_CYCLES - 1);
`endif

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DEBOUNCE = 2'd1,
    S_HELD     = 2'd2,
    S_RELEASE  = 2'd3
  } state_t;

  logic [15:0]   sync1;
  logic [15:0]   ks;
  logic          any;
  logic [3:0]    code;

  state_t        state;
  state_t        state_nx;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nx;
  logic [3:0]    cap;
  logic [3:0]    cap_nx;
  logic          pressed_nx;
  logic [3:0]    bus_nx;
  logic          rep_key;

  // Two-flop synchronizer on every raw key line.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync1 <= '0;
      ks    <= '0;
    end else begin
      sync1 <= keys;
      ks    <= sync1;
    end
  end

  // Priority encoder: the highest set bit wins.
  always_comb begin
    any  = |ks;
    code = 4'h0;
    for (int i = 0; i < 16; i++) begin
      if (ks[i]) code = 4'(i);
    end
  end

  assign rep_key = (cap == 4'hC) || (cap == 4'hD);

  // State, counter, captured code and registered outputs.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      cap       <= 4'h0;
      pressed   <= 1'b0;
      buttonBus <= 4'h0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      cap       <= cap_nx;
      pressed   <= pressed_nx;
      buttonBus <= bus_nx;
    end
  end

  // Next-state, counter and capture logic.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    cap_nx   = cap;
    case (state)
      S_IDLE: begin
        if (any) begin
          state_nx = S_DEBOUNCE;
          cap_nx   = code;
          cnt_nx   = '0;
        end
      end
      S_DEBOUNCE: begin
        if (!any || (code != cap)) begin
          // Going through IDLE lets a higher key restart debounce next cycle.
          state_nx = S_IDLE;
          cnt_nx   = '0;
        end else if (cnt == DB_LAST) begin
          state_nx = S_HELD;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      S_HELD: begin
        if (!any) begin
          state_nx = S_RELEASE;
          cnt_nx   = '0;
        end
`ifdef KEYPAD_REPEAT_EN
        else if ((code == cap) && rep_key) begin
          if (cnt == RP_LAST) cnt_nx = '0;
          else                cnt_nx = cnt + 1'b1;
        end
`endif
      end
      S_RELEASE: begin
        if (any) begin
          state_nx = S_HELD;
          cnt_nx   = '0;
        end else if (cnt == DB_LAST) begin
          state_nx = S_IDLE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: begin
        state_nx = S_IDLE;
        cnt_nx   = '0;
        cap_nx   = 4'h0;
      end
    endcase
  end

  // Strobe decode; outputs idle at zero whenever no event is emitted.
  always_comb begin
    pressed_nx = 1'b0;
    bus_nx     = 4'h0;
    case (state)
      S_DEBOUNCE: begin
        if (any && (code == cap) && (cnt == DB_LAST)) begin
          pressed_nx = 1'b1;
          bus_nx     = cap;
        end
      end
`ifdef KEYPAD_REPEAT_EN
      S_HELD: begin
        if (any && (code == cap) && rep_key && (cnt == RP_LAST)) begin
          pressed_nx = 1'b1;
          bus_nx     = cap;
        end
      end
`endif
      default: begin
        pressed_nx = 1'b0;
        bus_nx     = 4'h0;
      end
    endcase
  end

endmodule

// File: tb/tb_keypad_sync.sv
// Bench for keypad_sync: directed scenarios followed by random key waveforms,
// all checked every cycle against a run-length reference model.
module tb_keypad_sync;

  localparam int DB  = 16;
  localparam int REP = 200;

  logic        clk = 1'b0;
  logic        n_rst;
  logic [15:0] keys;
  logic [3:0]  buttonBus;
  logic        pressed;

  int total = 0;
  int bad   = 0;
  int cyc;
  int nstrobe;
  int last_strobe;

  // Reference model state: key history seen through the synchronizer delay,
  // plus run lengths of stable press / release.
  logic [15:0] d1, d2;
  bit          m_held;
  int          m_run, m_code, m_zero, m_rep;
  bit          e_pr;
  logic [3:0]  e_bus;

  always #5 clk = ~clk;

  keypad_sync #(.DEBOUNCE_CYCLES(DB), .REPEAT_CYCLES(REP)) dut (
    .clk(clk), .n_rst(n_rst), .keys(keys), .buttonBus(buttonBus), .pressed(pressed)
  );

  function automatic int top_index(input logic [15:0] v);
    int r = -1;
    for (int i = 0; i < 16; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic model_reset();
    d1 = '0; d2 = '0;
    m_held = 0; m_run = 0; m_code = 0; m_zero = 0; m_rep = 0;
    e_pr = 0; e_bus = 4'h0;
  endtask

  task automatic model_edge();
    int idx;
    idx   = top_index(d2);
    e_pr  = 0;
    e_bus = 4'h0;
    if (!m_held) begin
      if (m_run == 0) begin
        if (idx >= 0) begin m_run = 1; m_code = idx; end
      end else if (idx == m_code) begin
        m_run++;
        if (m_run == DB + 1) begin
          e_pr = 1; e_bus = 4'(m_code);
          m_held = 1; m_run = 0; m_zero = 0; m_rep = 0;
        end
      end else begin
        m_run = 0;
      end
    end else begin
      if (idx < 0) begin
        m_zero++; m_rep = 0;
        if (m_zero == DB + 1) begin m_held = 0; m_zero = 0; end
      end else if (m_zero > 0) begin
        m_zero = 0; m_rep = 0;
      end
`ifdef KEYPAD_REPEAT_EN
      else if (idx == m_code && (m_code == 12 || m_code == 13)) begin
        m_rep++;
        if (m_rep == REP) begin e_pr = 1; e_bus = 4'(m_code); m_rep = 0; end
      end
`endif
    end
    d2 = d1;
    d1 = keys;
  endtask

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step(input logic [15:0] k);
    keys = k;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    cyc++;
    if (pressed === 1'b1) begin nstrobe++; last_strobe = cyc; end
    total++;
    assert (pressed === e_pr) else begin
      bad++;
      $error("FAIL pressed cyc=%0d got=%b exp=%b", cyc, pressed, e_pr);
    end
    total++;
    assert (buttonBus === e_bus) else begin
      bad++;
      $error("FAIL buttonBus cyc=%0d got=%h exp=%h", cyc, buttonBus, e_bus);
    end
  endtask

  task automatic run(input logic [15:0] k, input int n);
    repeat (n) step(k);
  endtask

  task automatic seg();
    cyc = 0; nstrobe = 0; last_strobe = -1;
  endtask

  task automatic do_reset(input int n);
    n_rst = 1'b0;
    model_reset();
    repeat (n) begin
      @(negedge clk);
      chk("rst_pressed", int'(pressed), 0);
      chk("rst_bus", int'(buttonBus), 0);
    end
    n_rst = 1'b1;
    seg();
  endtask

  initial begin
    int n_keep;
    logic [15:0] pat;
    keys = 16'h8000;
    n_rst = 1'b0;
    model_reset();
    seg();

    // Reset held with a key down, then the key is a new press after release.
    do_reset(6);
    run(16'h8000, 40);
    chk("rst_release_count", nstrobe, 1);
    chk("rst_release_latency", last_strobe, 19);
    run(16'h0000, 25);

    // Clean press of key B.
    seg();
    run(16'h0800, 100);
    run(16'h0000, 25);
    chk("clean_count", nstrobe, 1);
    chk("clean_latency", last_strobe, 19);

    // Bounce on key 0 followed by a stable press.
    seg();
    repeat (6) begin run(16'h0001, 5); run(16'h0000, 5); end
    chk("bounce_none", nstrobe, 0);
    seg();
    run(16'h0001, 40);
    chk("bounce_count", nstrobe, 1);
    chk("bounce_latency", last_strobe, 19);
    run(16'h0000, 25);

    // Priority, added key while held, release glitch, then full release.
    seg();
    run(16'h0024, 40);
    run(16'h0424, 60);
    chk("prio_count", nstrobe, 1);
    run(16'h0000, 8);
    run(16'h0024, 50);
    chk("glitch_no_strobe", nstrobe, 1);
    run(16'h0000, 25);
    run(16'h0024, 40);
    chk("repress_count", nstrobe, 2);
    run(16'h0000, 25);

    // Higher key arriving during debounce restarts with the new code.
    seg();
    run(16'h0002, 6);
    run(16'h0202, 40);
    chk("restart_count", nstrobe, 1);
    chk("restart_latency", last_strobe, 6 + 20);
    run(16'h0000, 25);

    // Long holds: UP repeats only in the repeat build; key F never repeats.
    seg();
    run(16'h1000, 700);
`ifdef KEYPAD_REPEAT_EN
    chk("hold_up_count", nstrobe, 4);
`else
    chk("hold_up_count", nstrobe, 1);
`endif
    run(16'h0000, 25);
    seg();
    run(16'h8000, 700);
    chk("hold_f_count", nstrobe, 1);
    run(16'h0000, 25);

    // Reset in the middle of a debounce drops it; key still down re-presses.
    seg();
    run(16'h0800, 10);
    do_reset(3);
    run(16'h0800, 40);
    chk("midrst_count", nstrobe, 1);
    chk("midrst_latency", last_strobe, 19);
    run(16'h0000, 25);

    // Random key waveforms against the model.
    for (int s = 0; s < 300; s++) begin
      case ($urandom_range(0, 8))
        0, 1:    pat = 16'h0000;
        2:       pat = 16'h0001;
        3:       pat = 16'h1000;
        4:       pat = 16'h2000;
        5:       pat = 16'h0024;
        6:       pat = 16'h8000;
        7:       pat = 16'(1 << $urandom_range(0, 15));
        default: pat = 16'($urandom);
      endcase
      n_keep = (($urandom_range(0, 3) == 0) ? int'($urandom_range(30, 260))
                                             : int'($urandom_range(1, 24)));
      run(pat, n_keep);
      if ($urandom_range(0, 49) == 0) do_reset(2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
